// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared types and helpers for the ball slot manager
package ball_pkg;

    localparam int MULTIPLIER = 64;

    typedef logic [1:0] level_t;
    typedef int speed_t;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ALLOC,
        HOLD,
        DONE
    } state_t;

    typedef struct packed {
        logic        active;
        level_t      level;
        logic [10:0] initX;
        logic [10:0] initY;
        speed_t      xs;
        speed_t      ys;
    } slot_t;

    // A freshly loaded slot stays inactive until its local reset is released.
    function automatic slot_t make_slot(level_t lvl, logic [10:0] x, logic [10:0] y,
                                        speed_t xs, speed_t ys);
        slot_t s;
        s.active = 1'b0;
        s.level  = lvl;
        s.initX  = x;
        s.initY  = y;
        s.xs     = xs;
        s.ys     = ys;
        return s;
    endfunction

endpackage

// File: rtl/ball_split_ctrl_if.sv
// rtl/ball_split_ctrl_if.sv - game-start and rope-hit request bus
interface ball_split_ctrl_if #(
    parameter int NUM_SLOTS = 4
);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic             startGame;
    logic [10:0]      spawnX;
    logic [10:0]      spawnY;
    logic             hitReq;
    logic [IDX_W-1:0] hitSlot;
    logic             hitAck;

    modport master (
        output startGame, spawnX, spawnY, hitReq, hitSlot,
        input  hitAck
    );

    modport slave (
        input  startGame, spawnX, spawnY, hitReq, hitSlot,
        output hitAck
    );

endinterface

// File: rtl/ball_slot_finder.sv
// rtl/ball_slot_finder.sv - lowest-index free slot search with one excluded index
module ball_slot_finder #(
    parameter int NUM_SLOTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_SLOTS-1:0] i_active,
    input  logic [IDX_W-1:0]     i_exclude,
    output logic                 o_found,
    output logic [IDX_W-1:0]     o_idx
);

    // Scan downwards so the lowest matching index is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!i_active[i] && (IDX_W'(i) != i_exclude)) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ball_split_ctrl.sv
// rtl/ball_split_ctrl.sv - ball slot manager: spawns, splits and kills balls
module ball_split_ctrl
    import ball_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int MAX_LEVEL    = 2,
    parameter int SPLIT_XSPEED = MULTIPLIER,
    parameter int SPLIT_YSPEED = -3 * MULTIPLIER,
    parameter int RST_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 resetN,
    ball_split_ctrl_if.slave     bus,
    input  logic [10:0]          posX [NUM_SLOTS],
    input  logic [10:0]          posY [NUM_SLOTS],
    output logic [NUM_SLOTS-1:0] slotResetN,
    output logic [NUM_SLOTS-1:0] slotActive,
    output level_t               slotLevel [NUM_SLOTS],
    output logic [10:0]          initX [NUM_SLOTS],
    output logic [10:0]          initY [NUM_SLOTS],
    output speed_t               initXspeed [NUM_SLOTS],
    output speed_t               initYspeed [NUM_SLOTS],
    output logic                 allCleared,
    output logic                 busy
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
    localparam logic [NUM_SLOTS-1:0] ONE = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

    state_t               r_state, w_next;
    slot_t                r_slot [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_rst_n, r_mark;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_hit_ep, r_cleared, r_armed;
    logic [IDX_W-1:0]     r_par_idx;
    logic                 r_par_ok;
    level_t               r_par_lvl;
    logic [10:0]          r_par_x, r_par_y;

    logic [NUM_SLOTS-1:0] w_active, w_par_bit, w_free_bit;
    logic                 w_hit_ok, w_accept_hit, w_free_found;
    logic [IDX_W-1:0]     w_hit_idx, w_free_idx;
    level_t               w_child_lvl;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) w_active[i] = r_slot[i].active;
    end

    assign w_hit_ok     = int'(bus.hitSlot) < NUM_SLOTS;
    assign w_hit_idx    = w_hit_ok ? bus.hitSlot : '0;
    assign w_accept_hit = (r_state == IDLE) && !bus.startGame && bus.hitReq && r_armed;
    assign w_par_bit    = ONE << r_par_idx;
    assign w_free_bit   = w_free_found ? (ONE << w_free_idx) : '0;
    assign w_child_lvl  = r_par_lvl - 2'd1;

    ball_slot_finder #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) u_finder (
        .i_active  (w_active),
        .i_exclude (r_par_idx),
        .o_found   (w_free_found),
        .o_idx     (w_free_idx)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.startGame) w_next = HOLD;
                     else if (w_accept_hit) w_next = LATCH;
            LATCH:   w_next = ALLOC;
            ALLOC:   w_next = (r_par_ok && (r_par_lvl != '0)) ? HOLD : DONE;
            HOLD:    if (r_cnt == CNT_W'(RST_CYCLES)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != IDLE);
        bus.hitAck = (r_state == DONE) && r_hit_ep;
        allCleared = (r_state == DONE) && r_cleared;
        slotResetN = r_rst_n;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slotActive[i] = r_slot[i].active;
            slotLevel[i]  = r_slot[i].level;
            initX[i]      = r_slot[i].initX;
            initY[i]      = r_slot[i].initY;
            initXspeed[i] = r_slot[i].xs;
            initYspeed[i] = r_slot[i].ys;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_SLOTS; i++) r_slot[i] <= '0;
            r_rst_n   <= '0;
            r_mark    <= '0;
            r_cnt     <= '0;
            r_hit_ep  <= 1'b0;
            r_cleared <= 1'b0;
            r_armed   <= 1'b0;
            r_par_idx <= '0;
            r_par_ok  <= 1'b0;
            r_par_lvl <= '0;
            r_par_x   <= '0;
            r_par_y   <= '0;
        end else begin
            // A held request re-arms only after it has been seen low.
            if (!bus.hitReq)       r_armed <= 1'b1;
            else if (w_accept_hit) r_armed <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.startGame) begin
                        for (int i = 0; i < NUM_SLOTS; i++) r_slot[i].active <= 1'b0;
                        r_slot[0] <= make_slot(level_t'(MAX_LEVEL), bus.spawnX, bus.spawnY,
                                               SPLIT_XSPEED, 0);
                        r_rst_n   <= '0;
                        r_mark    <= ONE;
                        r_cnt     <= '0;
                        r_hit_ep  <= 1'b0;
                        r_cleared <= 1'b0;
                    end else if (w_accept_hit) begin
                        r_hit_ep  <= 1'b1;
                        r_cleared <= 1'b0;
                    end
                end
                LATCH: begin
                    r_par_idx <= w_hit_idx;
                    r_par_ok  <= w_hit_ok && w_active[w_hit_idx];
                    r_par_lvl <= r_slot[w_hit_idx].level;
                    r_par_x   <= posX[w_hit_idx];
                    r_par_y   <= posY[w_hit_idx];
                end
                ALLOC: begin
                    r_cnt <= '0;
                    if (r_par_ok && (r_par_lvl == '0)) begin
                        r_slot[r_par_idx].active <= 1'b0;
                        r_rst_n[r_par_idx]       <= 1'b0;
                        r_cleared                <= ((w_active & ~w_par_bit) == '0);
                    end else if (r_par_ok) begin
                        r_slot[r_par_idx] <= make_slot(w_child_lvl, r_par_x, r_par_y,
                                                       -SPLIT_XSPEED, SPLIT_YSPEED);
                        r_rst_n[r_par_idx] <= 1'b0;
                        r_mark <= w_par_bit | w_free_bit;
                        if (w_free_found) begin
                            r_slot[w_free_idx] <= make_slot(w_child_lvl, r_par_x, r_par_y,
                                                            SPLIT_XSPEED, SPLIT_YSPEED);
                            r_rst_n[w_free_idx] <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (r_mark[i]) begin
                                r_rst_n[i]       <= 1'b1;
                                r_slot[i].active <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_split_ctrl.sv
// tb/tb_ball_split_ctrl.sv - scoreboard bench for ball_split_ctrl
module tb_ball_split_ctrl;
    import ball_pkg::*;

    localparam int NS   = 4;
    localparam int MAXL = 3;
    localparam int XS   = 64;
    localparam int YS   = -192;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    ball_split_ctrl_if #(.NUM_SLOTS(NS)) bus ();

    logic [10:0]   posX [NS];
    logic [10:0]   posY [NS];
    logic [NS-1:0] slotResetN, slotActive;
    level_t        slotLevel [NS];
    logic [10:0]   initX [NS];
    logic [10:0]   initY [NS];
    speed_t        initXspeed [NS];
    speed_t        initYspeed [NS];
    logic          allCleared, busy;

    ball_split_ctrl #(.NUM_SLOTS(NS), .MAX_LEVEL(MAXL)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .bus        (bus),
        .posX       (posX),
        .posY       (posY),
        .slotResetN (slotResetN),
        .slotActive (slotActive),
        .slotLevel  (slotLevel),
        .initX      (initX),
        .initY      (initY),
        .initXspeed (initXspeed),
        .initYspeed (initYspeed),
        .allCleared (allCleared),
        .busy       (busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    int    exp_q [$];
    string tag_q [$];
    int m_act [NS], m_lvl [NS], m_x [NS], m_y [NS], m_xs [NS], m_ys [NS];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    task automatic sb_chk(logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_underflow: observed %0d expected none", obs);
        end else begin
            chk(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    function automatic logic [31:0] dut_field(int i, int f);
        case (f)
            0:       return {31'b0, slotActive[i]};
            1:       return {31'b0, slotResetN[i]};
            2:       return {30'b0, slotLevel[i]};
            3:       return {21'b0, initX[i]};
            4:       return {21'b0, initY[i]};
            5:       return initXspeed[i];
            default: return initYspeed[i];
        endcase
    endfunction

    // Quiescent state: live slots are released, all others parked in reset.
    function automatic int model_field(int i, int f);
        case (f)
            0, 1:    return m_act[i];
            2:       return m_lvl[i];
            3:       return m_x[i];
            4:       return m_y[i];
            5:       return m_xs[i];
            default: return m_ys[i];
        endcase
    endfunction

    task automatic push_state(string tag);
        for (int i = 0; i < NS; i++)
            for (int f = 0; f < 7; f++) begin
                exp_q.push_back(model_field(i, f));
                tag_q.push_back($sformatf("%s.s%0d.f%0d", tag, i, f));
            end
    endtask

    task automatic pop_state();
        for (int i = 0; i < NS; i++)
            for (int f = 0; f < 7; f++) sb_chk(dut_field(i, f));
    endtask

    task automatic chk_zero(string tag);
        for (int i = 0; i < NS; i++)
            for (int f = 0; f < 7; f++) chk($sformatf("%s.s%0d.f%0d", tag, i, f), dut_field(i, f), 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".ack"}, bus.hitAck, 0);
        chk({tag, ".clr"}, allCleared, 0);
    endtask

    task automatic load(int i, int l, int x, int y, int xs, int ys);
        m_act[i] = 1; m_lvl[i] = l; m_x[i] = x; m_y[i] = y; m_xs[i] = xs; m_ys[i] = ys;
    endtask

    task automatic do_start(int x, int y, string tag);
        int n;
        for (int i = 0; i < NS; i++) m_act[i] = 0;
        load(0, MAXL, x, y, XS, 0);
        push_state(tag);
        @(negedge clk);
        bus.spawnX = 11'(x); bus.spawnY = 11'(y); bus.startGame = 1'b1;
        @(negedge clk);
        bus.startGame = 1'b0;
        chk({tag, ".rst_lo1"}, slotResetN[0], 0);
        chk({tag, ".busy"}, busy, 1);
        @(negedge clk);
        chk({tag, ".rst_lo2"}, slotResetN[0], 0);
        @(negedge clk);
        chk({tag, ".rst_rel"}, slotResetN[0], 1);
        n = 0;
        while (n < 20 && busy) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".idle"}, busy, 0);
        pop_state();
    endtask

    task automatic do_hit(int s, int px, int py, string tag);
        int lat, clr, n, f;
        lat = 3;
        clr = 0;
        if (m_act[s] != 0) begin
            if (m_lvl[s] == 0) begin
                m_act[s] = 0;
                clr = 1;
                for (int j = 0; j < NS; j++) if (m_act[j] != 0) clr = 0;
            end else begin
                f = -1;
                for (int j = NS - 1; j >= 0; j--) if (m_act[j] == 0 && j != s) f = j;
                load(s, m_lvl[s] - 1, px, py, -XS, YS);
                if (f >= 0) load(f, m_lvl[s], px, py, XS, YS);
                lat = 6;
            end
        end
        exp_q.push_back(lat); tag_q.push_back({tag, ".lat"});
        exp_q.push_back(clr); tag_q.push_back({tag, ".clr"});
        push_state(tag);

        @(negedge clk);
        posX[s] = 11'(px); posY[s] = 11'(py);
        bus.hitSlot = 2'(s); bus.hitReq = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (bus.hitAck === 1'b1) break;
        end
        sb_chk(n);
        sb_chk({31'b0, allCleared});
        repeat (2) begin @(posedge clk); #1; end
        chk({tag, ".held_idle"}, busy, 0);
        chk({tag, ".ack_pulse"}, bus.hitAck, 0);
        bus.hitReq = 1'b0;
        @(posedge clk); #1;
        pop_state();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acks;
        bus.startGame = 1'b0; bus.spawnX = '0; bus.spawnY = '0;
        bus.hitReq = 1'b0; bus.hitSlot = '0;
        for (int i = 0; i < NS; i++) begin
            posX[i] = '0; posY[i] = '0;
            m_act[i] = 0; m_lvl[i] = 0; m_x[i] = 0; m_y[i] = 0; m_xs[i] = 0; m_ys[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) resetN = 1'b1;

        do_start(100, 50, "start");
        do_hit(0, 300, 200, "split_s0");
        do_hit(0, 40, 60, "split_s0b");
        do_hit(1, 500, 400, "split_s1");
        do_hit(2, 222, 111, "full_s2");
        do_hit(2, 5, 5, "kill_s2");
        do_hit(0, 10, 20, "split_s0c");
        do_hit(1, 30, 40, "full_s1");
        do_hit(3, 50, 60, "full_s3");
        do_hit(0, 1, 1, "kill_s0");
        do_hit(1, 1, 1, "kill_s1");
        do_hit(2, 1, 1, "kill_s2b");
        do_hit(3, 1, 1, "kill_last");
        do_hit(3, 77, 88, "inactive_s3");

        do_start(20, 30, "start2");
        @(negedge clk);
        posX[0] = 11'd600; posY[0] = 11'd70; bus.hitSlot = 2'd0; bus.hitReq = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("rsthold.busy", busy, 1);
        chk("rsthold.parked", slotResetN[0], 0);
        resetN = 1'b0;
        #1 chk_zero("rsthold");
        bus.hitReq = 1'b0;
        @(negedge clk) resetN = 1'b1;
        acks = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.hitAck === 1'b1) acks++;
        end
        chk("rsthold.noack", acks, 0);
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 0; m_lvl[i] = 0; m_x[i] = 0; m_y[i] = 0; m_xs[i] = 0; m_ys[i] = 0;
        end
        do_start(7, 9, "restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_split_ctrl.md
Name: ball_split_ctrl

Overview:
- Slot manager sitting directly upstream of the per-ball trajectory generators.
- Owns NUM_SLOTS ball slots; per slot it drives the generator's initial position/speed and a local active-low reset.
- On a game start it spawns one large ball. On a rope hit it splits the hit ball into two smaller children, or kills it at the smallest level.
- Reads back each slot's current on-screen top-left position to seed the children.

Parameters:
- NUM_SLOTS, 4, number of ball slots / trajectory instances (2..8).
- MAX_LEVEL, 2, size level of the spawned ball; level 0 = smallest, never splits.
- SPLIT_XSPEED, 64, absolute child X speed, in 1/64 px per frame.
- SPLIT_YSPEED, -192, child initial Y speed (upward kick), 1/64 px per frame.
- RST_CYCLES, 2, clocks a slot's local reset is held low when (re)loaded.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startGame  in  1  single-cycle pulse: clear all slots, spawn one ball
- spawnX  in  11  spawn top-left X, px
- spawnY  in  11  spawn top-left Y, px
- hitReq  in  1  level request: slot hitSlot was hit; held until hitAck
- hitSlot  in  $clog2(NUM_SLOTS)  index of the hit slot
- posX  in  [NUM_SLOTS][11]  current top-left X of each slot, px
- posY  in  [NUM_SLOTS][11]  current top-left Y of each slot, px
- slotResetN  out  [NUM_SLOTS]  per-slot reset to trajectory instance, active low
- slotActive  out  [NUM_SLOTS]  slot holds a live ball
- slotLevel  out  [NUM_SLOTS][2]  size level per slot
- initX, initY  out  [NUM_SLOTS][11]  initial position per slot
- initXspeed, initYspeed  out  [NUM_SLOTS] int  initial speeds, signed 32-bit
- hitAck  out  1  one-cycle pulse: hit request consumed
- allCleared  out  1  one-cycle pulse: last ball killed
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - slotResetN all 0: inactive slots are parked in reset.
  - slotActive, slotLevel, initX/Y, initXspeed/Yspeed, hitAck, allCleared, busy all 0.
  - FSM in IDLE.
- FSM states: IDLE, LATCH, ALLOC, HOLD, DONE.
- IDLE:
  - startGame has priority over hitReq.
  - On startGame: clear every slot (active=0, slotResetN=0). Load slot 0 with initX=spawnX, initY=spawnY, Xspeed=+SPLIT_XSPEED, Yspeed=0, level=MAX_LEVEL. Go to HOLD with slot 0 marked for release.
  - On hitReq: go to LATCH.
- LATCH: register hitSlot, posX[hitSlot], posY[hitSlot], and level. Go to ALLOC.
- ALLOC, inactive parent: no change; go to DONE.
- ALLOC, level 0 parent: slotActive=0, slotResetN=0. If no slot remains active, assert allCleared in DONE. Go to DONE.
- ALLOC, level>0 parent:
  - Child A reuses the parent slot: level-1, init=(latched pos), Xspeed=-SPLIT_XSPEED, Yspeed=SPLIT_YSPEED.
  - Child B takes the lowest-index inactive slot other than the parent: same values but Xspeed=+SPLIT_XSPEED.
  - If no free slot exists, only child A is created; not an error.
  - Assert slotResetN=0 on the child slots. Go to HOLD.
- HOLD:
  - Marked slots keep slotResetN=0 for exactly RST_CYCLES clocks, counted from the HOLD entry cycle.
  - Then release them together: slotResetN=1, slotActive=1. Go to DONE.
- DONE:
  - hitAck=1 for one cycle, only if the episode was hit-initiated.
  - Return to IDLE. A still-high hitReq starts a new episode only once it has dropped and risen again; the requester must drop it after hitAck.
- init* registers change only in ALLOC/IDLE-spawn, and only for the slots being loaded; other slots are untouched.
- startGame while busy is ignored; no queueing.
- Latency from hitReq rise to child release is 3+RST_CYCLES clocks; hitAck follows 1 clock later.
- hitSlot ≥ NUM_SLOTS is treated as an inactive slot.
- resetN low mid-operation forces all reset values immediately (async); the in-flight episode is discarded and no ack is issued.

Decomposition:
- Package ball_pkg holds:
  - MULTIPLIER (64)
  - level typedef (logic [1:0])
  - speed typedef (int)
  - FSM state enum
  - slot record struct {active, level, initX, initY, xs, ys}
- One sub-module: ball_slot_finder. Combinational lowest-index free-slot search with exclude index; outputs found flag plus index.

Test Plan:
- Reset, then startGame with spawnX=100, spawnY=50 -> slot0 slotResetN low 2 clocks then high; slotActive=0001; level0=2; initXspeed0=+64; initYspeed0=0.
- From that state, hitReq with hitSlot=0, posX[0]=300, posY[0]=200 -> slots 0 and 1 active at level 1, both init (300,200); Xspeed -64/+64; Yspeed -192 each; hitAck 1 pulse 6 clocks after hitReq.
- Hit a level-0 ball while it is the only active slot -> that slot parked (slotResetN=0); allCleared and hitAck pulse in the same cycle.
- All 4 slots active, hit a level-1 slot 2 -> only slot 2 reloaded as level 0, Xspeed -64; other slots unchanged.
- hitReq on inactive slot 3 -> hitAck after 3 clocks; all outputs unchanged.
- resetN pulsed low during HOLD -> all outputs 0 immediately; no hitAck afterwards; startGame works normally after release.
